// File: rtl/matmul_q2_14_pkg.sv
// matmul_q2_14_pkg
// Shared widths, Q2.14 limits, FSM state constants and the product-index
// to operand-index mapping for the sequential 2x2 Q2.14 matrix multiplier.
// No ports; imported by q2_14_mac and matmul_q2_14_seq.
package matmul_q2_14_pkg;

    localparam int DATA_W = 16;
    localparam int FRAC_W = 14;
    localparam int ACC_W  = 19;

    localparam logic signed [DATA_W-1:0] Q_MAX = 16'sh7FFF;
    localparam logic signed [DATA_W-1:0] Q_MIN = 16'sh8000;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_CALC  = 2'd1;
    localparam state_t ST_DRAIN = 2'd2;
    localparam state_t ST_DONE  = 2'd3;

    localparam logic [2:0] K_FIRST = 3'd0;
    localparam logic [2:0] K_LAST  = 3'd7;

    // Product k contributes to element C[row][col] with row=k[2], col=k[1]
    // and inner index j=k[0], so it needs A[row][j] * B[j][col].
    // Returned as {a_idx[1:0], b_idx[1:0]}, index = row*2 + col.
    function automatic logic [3:0] sel_operands(input logic [2:0] k);
        return {k[2], k[0], k[0], k[1]};
    endfunction

endpackage

// File: rtl/q2_14_mac.sv
// q2_14_mac
// Shared signed 16x16 multiplier with optional output register, floor shift
// by FRAC_W, 19-bit accumulate over pairs of products, finalise (wrap or
// clamp) and sticky overflow flag.
// Ports:
//   clk, rst_n    clock, async active-low reset
//   clear_i       start of a new transaction: clears sticky overflow
//   issue_i, k_i  product k_i is presented on a_i/b_i this cycle
//   a_i, b_i      Q2.14 operands
//   wr_o, idx_o   element idx_o is finalised this cycle (value on elem_o)
//   elem_o        finalised Q2.14 element
//   ovf_o         some element of this transaction wrapped or clamped
module q2_14_mac
    import matmul_q2_14_pkg::*;
#(
    parameter int SATURATE = 0,
    parameter int MUL_PIPE = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear_i,
    input  logic              issue_i,
    input  logic [2:0]        k_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic              wr_o,
    output logic [1:0]        idx_o,
    output logic [DATA_W-1:0] elem_o,
    output logic              ovf_o
);

    logic signed [31:0]      aExt;
    logic signed [31:0]      bExt;
    logic signed [31:0]      mulFull;
    logic signed [ACC_W-1:0] prodNow;
    logic                    stValid;
    logic [2:0]              stK;
    logic signed [ACC_W-1:0] stProd;
    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] acc_d;
    logic signed [ACC_W-1:0] sum;
    logic                    ovf_q;
    logic                    ovf_d;
    logic                    inRange;

    assign aExt    = {{(32-DATA_W){a_i[DATA_W-1]}}, a_i};
    assign bExt    = {{(32-DATA_W){b_i[DATA_W-1]}}, b_i};
    assign mulFull = aExt * bExt;
    // Arithmetic shift is floor division; the 18 significant bits fit in ACC_W.
    assign prodNow = ACC_W'(mulFull >>> FRAC_W);

    generate
        if (MUL_PIPE != 0) begin : gPipe
            logic                    stValid_q;
            logic [2:0]              stK_q;
            logic signed [ACC_W-1:0] stProd_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    stValid_q <= 1'b0;
                    stK_q     <= '0;
                    stProd_q  <= '0;
                end else begin
                    stValid_q <= issue_i && !clear_i;
                    stK_q     <= k_i;
                    stProd_q  <= prodNow;
                end
            end

            assign stValid = stValid_q;
            assign stK     = stK_q;
            assign stProd  = stProd_q;
        end else begin : gComb
            assign stValid = issue_i;
            assign stK     = k_i;
            assign stProd  = prodNow;
        end
    endgenerate

    // Even k starts a new element, odd k completes it. Overflow means the
    // 19-bit sum does not fit in 16 signed bits (top four bits disagree).
    always_comb begin
        sum     = acc_q + stProd;
        inRange = (sum[ACC_W-1:DATA_W-1] == {(ACC_W-DATA_W+1){sum[DATA_W-1]}});
        elem_o  = sum[DATA_W-1:0];
        if ((SATURATE != 0) && !inRange) begin
            elem_o = sum[ACC_W-1] ? Q_MIN : Q_MAX;
        end
        acc_d = acc_q;
        ovf_d = ovf_q;
        wr_o  = 1'b0;
        if (clear_i) begin
            ovf_d = 1'b0;
        end else if (stValid) begin
            if (!stK[0]) begin
                acc_d = stProd;
            end else begin
                wr_o = 1'b1;
                if (!inRange) begin
                    ovf_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            ovf_q <= ovf_d;
        end
    end

    assign idx_o = stK[2:1];
    assign ovf_o = ovf_q;

endmodule

// File: rtl/matmul_q2_14_seq.sv
// matmul_q2_14_seq
// Sequential 2x2 Q2.14 matrix multiply C = A x B using one shared multiplier
// over 8 product cycles, with valid/ready handshakes on both sides.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   in_valid, in_ready    operand handshake (accept only in IDLE)
//   a_mat, b_mat          {X11,X10,X01,X00}, X00 in [15:0], signed Q2.14
//   out_valid, out_ready  result handshake (held in DONE until accepted)
//   c_mat                 {C11,C10,C01,C00}, signed Q2.14
//   ovf                   some element wrapped/clamped, qualified by out_valid
//   busy                  not in IDLE
module matmul_q2_14_seq
    import matmul_q2_14_pkg::*;
#(
    parameter int SATURATE = 0,
    parameter int MUL_PIPE = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] a_mat,
    input  logic [63:0] b_mat,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] c_mat,
    output logic        ovf,
    output logic        busy
);

    state_t              state_q;
    state_t              state_d;
    logic [2:0]          k_q;
    logic [2:0]          k_d;
    logic [63:0]         a_q;
    logic [63:0]         a_d;
    logic [63:0]         b_q;
    logic [63:0]         b_d;
    logic [63:0]         c_q;
    logic [63:0]         c_d;
    logic                accept;
    logic                issue;
    logic [3:0]          sel;
    logic [DATA_W-1:0]   aSel;
    logic [DATA_W-1:0]   bSel;
    logic                macWr;
    logic [1:0]          macIdx;
    logic [DATA_W-1:0]   macElem;
    logic                macOvf;

    assign accept = in_valid && (state_q == ST_IDLE);
    assign issue  = (state_q == ST_CALC);
    assign sel    = sel_operands(k_q);
    assign aSel   = a_q[{sel[3:2], 4'b0000} +: DATA_W];
    assign bSel   = b_q[{sel[1:0], 4'b0000} +: DATA_W];

    q2_14_mac #(
        .SATURATE (SATURATE),
        .MUL_PIPE (MUL_PIPE)
    ) u_mac (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear_i (accept),
        .issue_i (issue),
        .k_i     (k_q),
        .a_i     (aSel),
        .b_i     (bSel),
        .wr_o    (macWr),
        .idx_o   (macIdx),
        .elem_o  (macElem),
        .ovf_o   (macOvf)
    );

    // With MUL_PIPE the last product is still in the multiplier register when
    // k wraps, so DRAIN gives it one cycle to reach the accumulator.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_d     = a_mat;
                    b_d     = b_mat;
                    k_d     = K_FIRST;
                    state_d = ST_CALC;
                end
            end
            ST_CALC: begin
                k_d = k_q + 3'd1;
                if (k_q == K_LAST) begin
                    state_d = (MUL_PIPE != 0) ? ST_DRAIN : ST_DONE;
                end
            end
            ST_DRAIN: begin
                state_d = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (macWr) begin
            c_d[{macIdx, 4'b0000} +: DATA_W] = macElem;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            k_q     <= K_FIRST;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);
    assign c_mat     = c_q;
    assign ovf       = macOvf;

endmodule

// File: tb/tb_matmul_q2_14_seq.sv
// tb_matmul_q2_14_seq
// Two instances: index 0 is SATURATE=0/MUL_PIPE=0, index 1 is
// SATURATE=1/MUL_PIPE=1. Directed vectors, identity and random pairs against
// a plain-arithmetic matrix model, backpressure, mid-run reset, back-to-back.
module tb_matmul_q2_14_seq;

    typedef struct {
        string       name;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] cWrap;
        logic        ovfWrap;
        logic [63:0] cSat;
        logic        ovfSat;
    } vec_t;

    logic        clk;
    logic        rstN;
    logic        inValid  [2];
    logic        inReady  [2];
    logic [63:0] aMat     [2];
    logic [63:0] bMat     [2];
    logic        outValid [2];
    logic        outReady [2];
    logic [63:0] cMat     [2];
    logic        ovfOut   [2];
    logic        busyOut  [2];

    int nChecks = 0;
    int nFails  = 0;

    localparam logic [63:0] NOM_A = 64'hC000_0000_2000_4000;
    localparam logic [63:0] NOM_B = 64'h4000_1000_0000_2000;
    localparam logic [63:0] IDENT = 64'h4000_0000_0000_4000;

    for (genvar g = 0; g < 2; g++) begin : gDut
        matmul_q2_14_seq #(
            .SATURATE (g),
            .MUL_PIPE (g)
        ) dut (
            .clk       (clk),
            .rst_n     (rstN),
            .in_valid  (inValid[g]),
            .in_ready  (inReady[g]),
            .a_mat     (aMat[g]),
            .b_mat     (bMat[g]),
            .out_valid (outValid[g]),
            .out_ready (outReady[g]),
            .c_mat     (cMat[g]),
            .ovf       (ovfOut[g]),
            .busy      (busyOut[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Matrix product from the arithmetic rules: each product floored by
    // 2^14, pairs summed exactly, then wrapped or clamped to 16 bits.
    function automatic logic [64:0] refModel(input logic [63:0] a, input logic [63:0] b, input int sat);
        longint ae [4];
        longint be [4];
        longint s;
        logic [63:0] c;
        logic        o;
        c = '0;
        o = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ae[i] = longint'($signed(a[16*i +: 16]));
            be[i] = longint'($signed(b[16*i +: 16]));
        end
        for (int r = 0; r < 2; r++) begin
            for (int col = 0; col < 2; col++) begin
                s = 0;
                for (int j = 0; j < 2; j++) begin
                    s = s + ((ae[r*2+j] * be[j*2+col]) >>> 14);
                end
                if (s > 32767 || s < -32768) o = 1'b1;
                if (sat != 0 && s > 32767)       c[16*(r*2+col) +: 16] = 16'h7FFF;
                else if (sat != 0 && s < -32768) c[16*(r*2+col) +: 16] = 16'h8000;
                else                             c[16*(r*2+col) +: 16] = 16'(s);
            end
        end
        return {o, c};
    endfunction

    function automatic logic [15:0] randElem();
        case ($urandom_range(0, 5))
            0:       return 16'h7FFF;
            1:       return 16'h8000;
            default: return 16'($urandom);
        endcase
    endfunction

    function automatic logic [63:0] randMat();
        logic [63:0] m;
        for (int i = 0; i < 4; i++) m[16*i +: 16] = randElem();
        return m;
    endfunction

    task automatic checkOutput(input string name, input int d, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s (dut%0d): got %h expected %h", name, d, act, exp);
        end
    endtask

    // Runs one transaction from posedge+1 with the block idle. lat counts
    // rising edges to out_valid with the accepting edge counted as edge 1.
    task automatic applyStimulus(input int d, input logic [63:0] a, input logic [63:0] b,
                                 output logic [63:0] c, output logic o, output int lat);
        int waitCnt;
        inValid[d] = 1'b1;
        aMat[d]    = a;
        bMat[d]    = b;
        waitCnt    = 0;
        while (!inReady[d] && waitCnt < 20) begin
            @(posedge clk); #1;
            waitCnt++;
        end
        @(posedge clk); #1;
        inValid[d] = 1'b0;
        aMat[d]    = {$urandom, $urandom};
        bMat[d]    = {$urandom, $urandom};
        lat = 1;
        while (!outValid[d] && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        c = cMat[d];
        o = ovfOut[d];
        outReady[d] = 1'b1;
        @(posedge clk); #1;
        outReady[d] = 1'b0;
    endtask

    task automatic testBackpressure(input int d);
        logic [64:0] exp;
        logic [63:0] nextA;
        logic [63:0] nextB;
        logic [63:0] c;
        logic        o;
        int          lat;
        exp = refModel(NOM_A, NOM_B, d);
        inValid[d] = 1'b1;
        aMat[d]    = NOM_A;
        bMat[d]    = NOM_B;
        @(posedge clk); #1;
        inValid[d] = 1'b0;
        lat = 1;
        while (!outValid[d] && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        checkOutput("bp first result", d, cMat[d], exp[63:0]);
        for (int i = 0; i < 5; i++) begin
            inValid[d] = (i % 2 == 0);
            aMat[d]    = randMat();
            bMat[d]    = randMat();
            @(posedge clk); #1;
            checkOutput("bp c_mat held", d, cMat[d], exp[63:0]);
            checkOutput("bp ovf held", d, 64'(ovfOut[d]), 64'(exp[64]));
            checkOutput("bp status {out_valid,in_ready,busy}", d,
                        64'({outValid[d], inReady[d], busyOut[d]}), 64'(3'b101));
        end
        nextA = randMat();
        nextB = randMat();
        inValid[d]  = 1'b1;
        aMat[d]     = nextA;
        bMat[d]     = nextB;
        outReady[d] = 1'b1;
        @(posedge clk); #1;
        outReady[d] = 1'b0;
        checkOutput("bp after handshake status", d,
                    64'({outValid[d], inReady[d], busyOut[d]}), 64'(3'b010));
        @(posedge clk); #1;
        inValid[d] = 1'b0;
        checkOutput("bp next accepted status", d,
                    64'({outValid[d], inReady[d], busyOut[d]}), 64'(3'b001));
        lat = 1;
        while (!outValid[d] && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        exp = refModel(nextA, nextB, d);
        c   = cMat[d];
        o   = ovfOut[d];
        checkOutput("bp second c_mat", d, c, exp[63:0]);
        checkOutput("bp second ovf", d, 64'(o), 64'(exp[64]));
        outReady[d] = 1'b1;
        @(posedge clk); #1;
        outReady[d] = 1'b0;
    endtask

    task automatic testResetMid(input int d);
        logic [63:0] c;
        logic        o;
        int          lat;
        logic [64:0] exp;
        inValid[d] = 1'b1;
        aMat[d]    = 64'h7FFF_7FFF_7FFF_7FFF;
        bMat[d]    = 64'h7FFF_7FFF_7FFF_7FFF;
        @(posedge clk); #1;
        inValid[d] = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        checkOutput("pre-reset busy/ovf", d, 64'({busyOut[d], ovfOut[d]}), 64'(2'b11));
        rstN = 1'b0;
        #1;
        checkOutput("mid reset c_mat", d, cMat[d], 64'h0);
        checkOutput("mid reset status {out_valid,in_ready,busy,ovf}", d,
                    64'({outValid[d], inReady[d], busyOut[d], ovfOut[d]}), 64'(4'b0100));
        @(posedge clk); #1;
        checkOutput("held reset out_valid", d, 64'(outValid[d]), 64'h0);
        rstN = 1'b1;
        exp = refModel(NOM_A, NOM_B, d);
        applyStimulus(d, NOM_A, NOM_B, c, o, lat);
        checkOutput("post-reset c_mat", d, c, exp[63:0]);
        checkOutput("post-reset ovf", d, 64'(o), 64'h0);
    endtask

    task automatic testBackToBack(input int d);
        logic [64:0] expQ [$];
        logic [64:0] e;
        int          cyc;
        int          lastCyc;
        int          nAcc;
        int          nRes;
        logic        acceptNow;
        cyc = 0; lastCyc = 0; nAcc = 0; nRes = 0;
        aMat[d]     = randMat();
        bMat[d]     = randMat();
        inValid[d]  = 1'b1;
        outReady[d] = 1'b1;
        while (nRes < 4 && cyc < 200) begin
            if (outValid[d]) begin
                if (expQ.size() == 0) begin
                    nChecks++;
                    nFails++;
                    $display("[TB] FAIL b2b unexpected result (dut%0d): got %h expected none", d, cMat[d]);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("b2b c_mat", d, cMat[d], e[63:0]);
                    checkOutput("b2b ovf", d, 64'(ovfOut[d]), 64'(e[64]));
                    if (nRes > 0) checkOutput("b2b spacing", d, 64'(cyc - lastCyc), 64'(10 + d));
                end
                lastCyc = cyc;
                nRes++;
            end
            acceptNow = inValid[d] && inReady[d];
            if (acceptNow) begin
                expQ.push_back(refModel(aMat[d], bMat[d], d));
                nAcc++;
            end
            @(posedge clk); #1;
            cyc++;
            if (acceptNow) begin
                if (nAcc == 4) begin
                    inValid[d] = 1'b0;
                end else begin
                    aMat[d] = randMat();
                    bMat[d] = randMat();
                end
            end
        end
        inValid[d]  = 1'b0;
        outReady[d] = 1'b0;
        checkOutput("b2b result count", d, 64'(nRes), 64'h4);
        @(posedge clk); #1;
    endtask

    initial begin
        vec_t        vecs [6];
        logic [63:0] c;
        logic        o;
        int          lat;
        logic [64:0] exp;
        logic [63:0] a;
        logic [63:0] b;

        vecs[0] = '{"nominal", NOM_A, NOM_B,
                    64'hC000_F000_2000_2800, 1'b0, 64'hC000_F000_2000_2800, 1'b0};
        vecs[1] = '{"all max", 64'h7FFF_7FFF_7FFF_7FFF, 64'h7FFF_7FFF_7FFF_7FFF,
                    64'hFFF8_FFF8_FFF8_FFF8, 1'b1, 64'h7FFF_7FFF_7FFF_7FFF, 1'b1};
        vecs[2] = '{"min squared", 64'h0000_0000_0000_8000, 64'h0000_0000_0000_8000,
                    64'h0000_0000_0000_0000, 1'b1, 64'h0000_0000_0000_7FFF, 1'b1};
        vecs[3] = '{"floor of negative", 64'h0000_0000_0000_FFFF, 64'h0000_0000_0000_0001,
                    64'h0000_0000_0000_FFFF, 1'b0, 64'h0000_0000_0000_FFFF, 1'b0};
        vecs[4] = '{"negative overflow", 64'h0000_0000_8000_8000, 64'h0000_7FFF_0000_7FFF,
                    64'h0000_0000_0000_0004, 1'b1, 64'h0000_0000_0000_8000, 1'b1};
        vecs[5] = '{"identity fixed", IDENT, 64'h1234_8765_7FFF_8000,
                    64'h1234_8765_7FFF_8000, 1'b0, 64'h1234_8765_7FFF_8000, 1'b0};

        rstN = 1'b0;
        for (int d = 0; d < 2; d++) begin
            inValid[d]  = 1'b0;
            outReady[d] = 1'b0;
            aMat[d]     = '0;
            bMat[d]     = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            checkOutput("reset c_mat", d, cMat[d], 64'h0);
            checkOutput("reset status {out_valid,in_ready,busy,ovf}", d,
                        64'({outValid[d], inReady[d], busyOut[d], ovfOut[d]}), 64'(4'b0100));
        end
        rstN = 1'b1;
        @(posedge clk); #1;

        $display("[TB] directed vectors");
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 6; i++) begin
                applyStimulus(d, vecs[i].a, vecs[i].b, c, o, lat);
                checkOutput({vecs[i].name, " c_mat"}, d, c, (d == 0) ? vecs[i].cWrap : vecs[i].cSat);
                checkOutput({vecs[i].name, " ovf"}, d, 64'(o),
                            64'((d == 0) ? vecs[i].ovfWrap : vecs[i].ovfSat));
                checkOutput({vecs[i].name, " latency"}, d, 64'(lat), 64'(9 + d));
                checkOutput({vecs[i].name, " out_valid dropped"}, d, 64'(outValid[d]), 64'h0);
            end
        end

        $display("[TB] identity with random B");
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 20; i++) begin
                b = {$urandom, $urandom};
                applyStimulus(d, IDENT, b, c, o, lat);
                checkOutput("identity c_mat", d, c, b);
                checkOutput("identity ovf", d, 64'(o), 64'h0);
            end
        end

        $display("[TB] random pairs against model");
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 500; i++) begin
                a = randMat();
                b = randMat();
                exp = refModel(a, b, d);
                applyStimulus(d, a, b, c, o, lat);
                checkOutput("random c_mat", d, c, exp[63:0]);
                checkOutput("random ovf", d, 64'(o), 64'(exp[64]));
            end
        end

        $display("[TB] backpressure, reset mid-run, back-to-back");
        for (int d = 0; d < 2; d++) begin
            testBackpressure(d);
            testResetMid(d);
            testBackToBack(d);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
